countdown_timer: RTL

Loadable down-counter (timer) with start/expire handshake. It is the decrementing counterpart to the team's incrementor datapath component. The next-count value is produced by a half-adder-style ripple decrementor (borrow chain) feeding a registered count. It sits beside the incrementor in the datapath library and serves delay/timeout generation for controllers.

---
 rtl/countdown_timer.sv | 101 ++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/expire handshake; next count comes from a borrow-ripple decrementor.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN for periodic reload at expiry instead of one-shot.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] all_zero;
  logic             busy_next;
  logic             done_next;
  logic             expire;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
`endif

  // Borrow ripple: bit i toggles when every lower bit is zero, so bit 0 always toggles.
  always_comb begin
    all_zero    = '0;
    all_zero[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      all_zero[i] = all_zero[i-1] & ~count[i-1];
    end
    count_dec = count ^ all_zero;
  end

  assign expire = (state == RUN) && en && (count == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_next;
      count <= count_next;
      busy  <= busy_next;
      done  <= done_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload <= reload_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_next = reload;
`endif
    if (load) begin
      count_next = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_next = load_val;
`endif
      state_next = (load_val != '0) ? RUN : IDLE;
    end else if ((state == RUN) && en) begin
      if (expire) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // A load always precedes RUN, so reload is never zero here.
        count_next = reload;
        state_next = RUN;
`else
        count_next = count_dec;
        state_next = IDLE;
`endif
      end else begin
        count_next = count_dec;
      end
    end
  end

  // A load of zero expires immediately; a load otherwise cancels any pending expiry.
  always_comb begin
    busy_next = (state_next == RUN);
    done_next = load ? (load_val == '0) : expire;
  end

endmodule
